// File: rtl/stim_player.sv
// stim_player: RAM-backed stimulus player with a register bus; define STIM_PLAYER_LOOP_EN to enable looped playback
package reg_map_pkg;
    localparam logic [31:0] R_STIM_INFO        = 32'h0001_0000;
    localparam logic [31:0] R_STIM_CTRL_STATUS = 32'h0001_0004;
    localparam logic [31:0] R_STIM_LEN         = 32'h0001_0008;
    localparam logic [31:0] R_STIM_IDLE        = 32'h0001_000C;
endpackage

module stim_player
    import reg_map_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger_in,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid,
    output logic             done_out,
    input  logic [31:0]      bus_addr,
    input  logic             bus_wen,
    input  logic             bus_ren,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] DEPTH32 = DEPTH;
    localparam logic [31:0] WIDTH32 = WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PLAY} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] smp_q;
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] idle_q;
    logic [15:0]      len_q;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    bus_idx;
    logic             trig_en;
    logic             loop_q;
    logic             done_sticky;
    logic             fin;
    logic             is_reg;
    logic             wr_ctrl;
    logic             wr_len;
    logic             wr_idle;
    logic             ram_we;
    logic             abort;
    logic             at_end;
    logic [31:0]      n_eff;
    logic [31:0]      status;

    assign bus_idx = bus_addr[AW+1:2];
    assign is_reg  = bus_addr inside {R_STIM_INFO, R_STIM_CTRL_STATUS, R_STIM_LEN, R_STIM_IDLE};
    assign wr_ctrl = bus_wen && bus_addr == R_STIM_CTRL_STATUS;
    assign wr_len  = bus_wen && bus_addr == R_STIM_LEN;
    assign wr_idle = bus_wen && bus_addr == R_STIM_IDLE;
    assign ram_we  = bus_wen && !is_reg && state == S_IDLE;
    assign abort   = wr_ctrl && !bus_wdata[0];

    // A zero or oversized length means the whole RAM; the top index always ends a pass so a shrunk LEN still terminates
    assign n_eff  = (len_q == 16'd0 || 32'(len_q) > DEPTH32) ? DEPTH32 : 32'(len_q);
    assign at_end = (32'(idx) + 32'd1 == n_eff) || (&idx);

    assign status     = (32'(idx) << 8) | {28'd0, done_sticky, loop_q, trig_en, state != S_IDLE};
    assign sample_out = sample_valid ? smp_q : idle_q;

    // Register and RAM-window read mux; RAM data is the word addressed last cycle and hidden while busy
    always_comb begin
        bus_rdata = !bus_ren                        ? 32'd0 :
                    bus_addr == R_STIM_INFO         ? {DEPTH32[15:0], WIDTH32[15:0]} :
                    bus_addr == R_STIM_CTRL_STATUS  ? status :
                    bus_addr == R_STIM_LEN          ? 32'(len_q) :
                    bus_addr == R_STIM_IDLE         ? 32'(idle_q) :
                    state == S_IDLE                 ? 32'(rd_q) : 32'd0;
    end

    // Sample RAM: bus write port, registered bus read port and registered playback read port
    always_ff @(posedge clk) begin
        if (ram_we) mem[bus_idx] <= bus_wdata[WIDTH-1:0];
        rd_q <= mem[bus_idx];
        if (state == S_PLAY) smp_q <= mem[idx];
    end

    // Control registers and IDLE/ARMED/PLAY sequencing with registered valid/done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            sample_valid <= 1'b0;
            done_out     <= 1'b0;
            done_sticky  <= 1'b0;
            fin          <= 1'b0;
            trig_en      <= 1'b0;
            loop_q       <= 1'b0;
            len_q        <= 16'd0;
            idle_q       <= '0;
        end else begin
            done_out     <= fin;
            fin          <= 1'b0;
            sample_valid <= 1'b0;
            if (fin) done_sticky <= 1'b1;
            if (wr_len) len_q <= bus_wdata[15:0];
            if (wr_idle) idle_q <= bus_wdata[WIDTH-1:0];
            if (wr_ctrl) trig_en <= bus_wdata[1];
`ifdef STIM_PLAYER_LOOP_EN
            if (wr_ctrl) loop_q <= bus_wdata[2];
`endif
            case (state)
                S_IDLE: begin
                    if (wr_ctrl && bus_wdata[0]) begin
                        state       <= bus_wdata[1] ? S_ARMED : S_PLAY;
                        idx         <= '0;
                        done_sticky <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (trigger_in) begin
                        state <= S_PLAY;
                        idx   <= '0;
                    end
                end
                S_PLAY: begin
                    if (abort) begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end else begin
                        sample_valid <= 1'b1;
                        idx          <= at_end ? '0 : idx + 1'b1;
                        if (at_end && !loop_q) begin
                            state <= S_IDLE;
                            fin   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/stim_player.md
STIM_PLAYER -- requirements
Module: stim_player

Interface
REQ-001 Parameter WIDTH, default 32: sample width in bits, 1..32.
REQ-002 Parameter DEPTH, default 1024: sample RAM entries, power of two; AW = $clog2(DEPTH).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 trigger_in  in  1  external start strobe, sampled in ARMED only.
REQ-006 sample_out  out  WIDTH  played sample, or idle value when not playing.
REQ-007 sample_valid  out  1  high exactly in cycles where sample_out carries a RAM sample.
REQ-008 done_out  out  1  one-cycle pulse on normal playback completion.
REQ-009 bus_addr  in  32, bus_wen  in  1, bus_ren  in  1, bus_wdata  in  32, bus_rdata  out  32: register bus; bus_rdata combinational.

Function
REQ-010 Registers decoded by full bus_addr compare against reg_map_pkg: R_STIM_INFO (RO), R_STIM_CTRL_STATUS, R_STIM_LEN, R_STIM_IDLE; all other addresses form the RAM window, index bus_addr[AW+1:2].
REQ-011 R_STIM_INFO reads {DEPTH[15:0], WIDTH[15:0]}.
REQ-012 R_STIM_CTRL_STATUS write: bit0 go, bit1 trig_en, bit2 loop; read: bit0 busy (state!=IDLE), bit1 trig_en, bit2 loop, bit3 done_sticky, bits31:8 current play index zero-extended, other bits 0.
REQ-013 R_STIM_LEN bits15:0 = sample count; 0 or >DEPTH plays DEPTH samples; reads back as written.
REQ-014 R_STIM_IDLE bits WIDTH-1:0 = value driven on sample_out when not playing.
REQ-015 RAM window write while IDLE stores bus_wdata[WIDTH-1:0]; writes while busy are dropped.
REQ-016 RAM window read returns the word at the address presented the previous cycle while IDLE; returns 0 while busy.
REQ-017 States IDLE, ARMED, PLAY.
REQ-018 IDLE: write to CTRL with go=1 -> ARMED if trig_en=1, else PLAY; clears done_sticky.
REQ-019 ARMED: trigger_in=1 -> PLAY next cycle; trigger_in in the cycle of the go write is ignored.
REQ-020 PLAY: read index starts at 0, increments by 1 per cycle; RAM read latency 1, so sample_out=RAM[i], sample_valid=1 the cycle after index i is issued.
REQ-021 First valid sample appears 1 cycle after entering PLAY; exactly N consecutive valid cycles for effective length N, no gaps.
REQ-022 loop=0: after index N-1 -> IDLE; sample_out returns to idle value and done_out pulses, with done_sticky set, in the cycle after the last valid sample.
REQ-023 loop=1: index N-1 wraps to 0 with no gap; no done_out; clearing loop mid-pass ends playback at that pass's end per REQ-022.
REQ-024 Write CTRL with go=0 in ARMED or PLAY -> IDLE next cycle; sample_valid low and sample_out idle from that cycle; no done_out; abort wins over simultaneous completion.
REQ-025 Write CTRL with go=1 while busy updates trig_en/loop only; no restart.
REQ-026 LEN and IDLE writes while busy take effect immediately; LEN reduced below current index ends play at next wrap point DEPTH-1.

Reset
REQ-027 rst: state IDLE, sample_out=0, sample_valid=0, done_out=0, done_sticky=0, trig_en=0, loop=0, LEN=0, IDLE=0, index=0; RAM contents not cleared.
REQ-028 rst mid-playback takes effect next edge with no done_out.

Configuration
REQ-029 Macro STIM_PLAYER_LOOP_EN: defined -> loop per REQ-023; undefined -> CTRL bit2 ignored on write, reads 0, playback always single-pass.

Verification
REQ-030 Load RAM[0..3]=1,2,3,4, LEN=4, IDLE=0xAA, go=1 trig_en=0 -> sample_out 1,2,3,4 with sample_valid on 4 cycles starting 2 cycles after the write edge, then 0xAA and one done_out.
REQ-031 trig_en=1, go=1, trigger_in held 0 for 10 cycles then pulsed -> busy=1, sample_valid=0 until trigger, first sample 2 cycles after trigger edge.
REQ-032 LEN=3, loop=1 (LOOP_EN defined) -> 1,2,3,1,2,3... gapless; go=0 write -> idle value next cycle, no done_out.
REQ-033 LEN=0, DEPTH=16 -> 16 valid samples; RAM write during play dropped, RAM readback after shows original data.
REQ-034 rst asserted at 3rd sample -> all outputs at reset values next cycle, busy=0, done_sticky=0.
